// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : Single-outstanding APB requester. Converts a valid/ready
//                command into an APB SETUP->ACCESS transfer and returns the
//                read data and error status on a valid/ready response port.
//                A wait-state timeout keeps a missing or hung responder from
//                stalling the command source.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  sel,
    output logic                  enable,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ready,
    input  logic                  slverr
);

    // Counter must be able to hold TIMEOUT without wrapping; keep at least
    // one bit so the design still elaborates when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        wait_q;
    logic                    sel_q;
    logic                    enable_q;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;

    // Only IDLE can take a new command; everything else is registered.
    assign cmd_ready   = (state_q == S_IDLE);

    assign sel         = sel_q;
    assign enable      = enable_q;
    assign write       = write_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    // Transfer sequencer: state, bus outputs, wait counter and response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            sel_q         <= 1'b0;
            enable_q      <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        write_q  <= cmd_write;
                        addr_q   <= cmd_addr;
                        wdata_q  <= cmd_wdata;
                        sel_q    <= 1'b1;
                        enable_q <= 1'b0;
                        state_q  <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    enable_q <= 1'b1;
                    wait_q   <= '0;
                    state_q  <= S_ACCESS;
                end

                S_ACCESS: begin
                    // A completing responder beats the timeout on the same cycle.
                    if (ready) begin
                        rsp_rdata_q   <= (write_q || slverr) ? '0 : rdata;
                        rsp_err_q     <= slverr;
                        rsp_timeout_q <= 1'b0;
                        sel_q         <= 1'b0;
                        enable_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else if ((TIMEOUT != 0) && (wait_q == c_CNT_LAST)) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        sel_q         <= 1'b0;
                        enable_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else if (wait_q != c_CNT_MAX) begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Self-checking bench for apb_master. A behavioural APB
//                responder with randomised wait states, errors and data is
//                checked against transfer-level expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          sel;
    logic          enable;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          slverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .sel         (sel),
        .enable      (enable),
        .write       (write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .slverr      (slverr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle cycles between transfers: nothing on the bus, no response.
    task automatic idle_cycles(input int k);
        cmd_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            ready     = 1'($urandom);
            rsp_ready = 1'($urandom);
            step();
            check_val("idle_cmd_ready", cmd_ready, 1);
            check_val("idle_sel",       sel,       0);
            check_val("idle_rsp_valid", rsp_valid, 0);
        end
        ready = 1'b0;
    endtask

    // One complete transfer. The responder completes after wait_n low-ready
    // ACCESS cycles; wait_n >= TO means it never answers. Entered and left
    // just after a negedge with the DUT expected in IDLE.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int wait_n, input logic serr, input logic [DW-1:0] rd,
                           input int rsp_delay);
        bit            timed_out;
        int            access_cycles;
        logic [DW-1:0] exp_rd;
        logic          exp_err;

        timed_out     = (wait_n >= TO);
        access_cycles = timed_out ? TO : wait_n + 1;
        exp_err       = timed_out ? 1'b1 : serr;
        exp_rd        = (timed_out || wr || serr) ? '0 : rd;

        check_val("start_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        step();

        // SETUP: select without enable; a competing command must be ignored.
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        check_val("setup_sel",       sel,       1);
        check_val("setup_enable",    enable,    0);
        check_val("setup_addr",      addr,      a);
        check_val("setup_write",     write,     wr);
        check_val("setup_wdata",     wdata,     wd);
        check_val("setup_cmd_ready", cmd_ready, 0);
        check_val("setup_rsp_valid", rsp_valid, 0);
        ready     = 1'($urandom);
        slverr    = 1'($urandom);
        rdata     = DW'($urandom);
        rsp_ready = 1'($urandom);
        step();

        // ACCESS: bus held stable for exactly access_cycles cycles.
        for (int n = 0; n < access_cycles; n++) begin
            check_val("access_sel",       sel,       1);
            check_val("access_enable",    enable,    1);
            check_val("access_addr",      addr,      a);
            check_val("access_write",     write,     wr);
            check_val("access_wdata",     wdata,     wd);
            check_val("access_cmd_ready", cmd_ready, 0);
            check_val("access_rsp_valid", rsp_valid, 0);
            cmd_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            if (!timed_out && n == wait_n) begin
                ready  = 1'b1;
                slverr = serr;
                rdata  = rd;
            end else begin
                ready  = 1'b0;
                slverr = 1'($urandom);
                rdata  = DW'($urandom);
            end
            step();
        end
        ready  = 1'b0;
        slverr = 1'b0;

        // RESP: fields stable under backpressure, bus idle.
        for (int d = 0; d <= rsp_delay; d++) begin
            check_val("resp_valid",     rsp_valid,   1);
            check_val("resp_rdata",     rsp_rdata,   exp_rd);
            check_val("resp_err",       rsp_err,     exp_err);
            check_val("resp_timeout",   rsp_timeout, timed_out);
            check_val("resp_sel",       sel,         0);
            check_val("resp_enable",    enable,      0);
            check_val("resp_cmd_ready", cmd_ready,   0);
            rsp_ready = (d == rsp_delay);
            cmd_valid = 1'($urandom);
            cmd_addr  = AW'($urandom);
            step();
        end
        check_val("done_rsp_valid", rsp_valid, 0);
        check_val("done_cmd_ready", cmd_ready, 1);
        check_val("done_sel",       sel,       0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Reset asserted while in ACCESS must drop the bus at once with no response.
    task automatic reset_mid_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd3;
        cmd_wdata = 8'h77;
        ready     = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check_val("rst_pre_enable", enable, 1);
        #2 reset = 1'b0;
        #1;
        check_val("rst_async_sel",       sel,       0);
        check_val("rst_async_enable",    enable,    0);
        check_val("rst_async_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        rdata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            check_val("rst_after_cmd_ready", cmd_ready, 1);
            check_val("rst_after_rsp_valid", rsp_valid, 0);
            check_val("rst_after_sel",       sel,       0);
            step();
        end
        ready = 1'b0;
    endtask

    initial begin
        int w;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        rdata     = '0;
        ready     = 1'b0;
        slverr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_sel",         sel,         0);
        check_val("reset_enable",      enable,      0);
        check_val("reset_write",       write,       0);
        check_val("reset_addr",        addr,        0);
        check_val("reset_wdata",       wdata,       0);
        check_val("reset_rsp_valid",   rsp_valid,   0);
        check_val("reset_rsp_rdata",   rsp_rdata,   0);
        check_val("reset_rsp_err",     rsp_err,     0);
        check_val("reset_rsp_timeout", rsp_timeout, 0);
        check_val("reset_cmd_ready",   cmd_ready,   1);
        reset = 1'b1;
        idle_cycles(2);

        // Directed cases.
        run_txn(1'b1, 2'd1, 8'h0A, 0,   1'b0, 8'h00, 0);   // plain write
        run_txn(1'b0, 2'd2, 8'h00, 3,   1'b0, 8'h5C, 0);   // read with 3 wait states
        run_txn(1'b1, 2'd2, 8'h33, 0,   1'b1, 8'h99, 0);   // slave error
        run_txn(1'b0, 2'd0, 8'h00, 100, 1'b0, 8'hAB, 1);   // timeout
        run_txn(1'b0, 2'd3, 8'h00, TO-1, 1'b0, 8'hC3, 0);  // ready on last timeout cycle
        run_txn(1'b0, 2'd1, 8'h00, 1,   1'b0, 8'h42, 5);   // backpressure
        run_txn(1'b1, 2'd2, 8'h81, 0,   1'b0, 8'h00, 0);   // immediately back-to-back
        reset_mid_access();
        run_txn(1'b0, 2'd3, 8'h00, 0,   1'b0, 8'h6D, 0);   // clean after reset

        // Randomised transfers.
        for (int t = 0; t < 40; t++) begin
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 5);
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), w, 1'($urandom_range(0, 3) == 0),
                    DW'($urandom), $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB requester that turns a simple valid/ready command into a full APB SETUP→ACCESS transfer.
- Drives the sel/enable/write/addr/wdata bus consumed by the peripheral responders (timer and friends) and returns rdata/slverr on a valid/ready response port.
- Adds a wait-state timeout so an absent or hung responder cannot stall the command source.

Parameters:
ADDR_WIDTH, 2, width of addr and cmd_addr.
DATA_WIDTH, 8, width of wdata/rdata and command/response data.
TIMEOUT, 16, maximum ACCESS cycles waiting for ready before an error response; 0 disables the timeout.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  ADDR_WIDTH  target address.
cmd_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at posedge.
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errored transfers.
rsp_err  output  1  slverr from the responder, or timeout.
rsp_timeout  output  1  error was caused by timeout.
sel  output  1  APB select.
enable  output  1  APB enable (ACCESS phase).
write  output  1  APB direction.
addr  output  ADDR_WIDTH  APB address.
wdata  output  DATA_WIDTH  APB write data.
rdata  input  DATA_WIDTH  APB read data.
ready  input  1  APB transfer complete.
slverr  input  1  APB error, valid while ready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - sel, enable, write, addr, wdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Wait counter 0.
  - Asserting reset mid-transfer aborts the transfer: the bus drops immediately and no response is produced.
- State machine: IDLE, SETUP, ACCESS, RESP. All bus and response outputs are registered.
- cmd_ready = (state==IDLE). It is the only combinational output.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_write/addr/wdata into write/addr/wdata, set sel=1 and enable=0, go to SETUP.
- SETUP (exactly 1 cycle):
  - Set enable=1, clear the wait counter, go to ACCESS.
- ACCESS (sel=1, enable=1):
  - addr, write and wdata are held stable for the whole transfer.
  - If ready=1 at posedge:
    - rsp_rdata = (write ? 0 : (slverr ? 0 : rdata)).
    - rsp_err = slverr; rsp_timeout = 0.
    - sel=0, enable=0, rsp_valid=1, go to RESP.
  - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1:
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - sel=0, enable=0, rsp_valid=1, go to RESP.
  - Else the counter increments (width clog2(TIMEOUT+1); it never wraps).
- RESP:
  - Response fields are held stable while rsp_valid=1.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_ready is ignored in every other state.
- Latency with ready=1 on the first ACCESS cycle and rsp_ready=1:
  - Accept at edge 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid high cycle 3, cmd_ready high again cycle 4.
  - Minimum command-to-command period: 4 cycles.
- Timeout timing: with no ready, ACCESS lasts exactly TIMEOUT cycles and rsp_valid rises on the following cycle.
- Boundary conditions:
  - ready=1 on the final timeout cycle: ready wins (normal completion, rsp_timeout=0).
  - slverr is ignored while ready=0.
  - cmd_valid while busy is not accepted; the command source must hold it.
  - sel is never high with enable high for more than one transfer without an intervening sel=0 cycle.

Test Plan:
- Write: cmd addr=1, wdata=8'h0A, write=1; ready high in first ACCESS → sel rises at cycle 1, enable at cycle 2, addr=1 and wdata=8'h0A stable; rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with wait states: addr=2, ready held low 3 ACCESS cycles, then ready=1 with rdata=8'h5C → rsp_rdata=8'h5C, rsp_err=0; enable high for 4 cycles.
- Slave error: write to addr=2 with ready=1, slverr=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=16, ready never asserted → ACCESS lasts exactly 16 cycles; rsp_err=1, rsp_timeout=1; sel/enable low afterwards. Second run with ready=1 on cycle 16 → normal completion.
- Backpressure and back-to-back: hold rsp_ready=0 for 5 cycles → rsp fields stable, cmd_ready=0, second cmd_valid not accepted; release → second transfer starts, next SETUP exactly 1 cycle after IDLE.
- Reset mid-ACCESS: drop reset during enable=1 → sel, enable, rsp_valid go 0 asynchronously; after release, cmd_ready=1 and no stale response appears.
